// File: rtl/pipelined_decode_pkg.sv
// Shared LEGv8 decode definitions: opcodes, ALU op classes, control bundle and the
// opcode classifier used by pipelined_decode.
package pipelined_decode_pkg;

  localparam int WORD_DEF  = 64;
  localparam int INSTR_LEN = 32;

  localparam logic [10:0] OP_ADD  = 11'b10001011000;
  localparam logic [10:0] OP_SUB  = 11'b11001011000;
  localparam logic [10:0] OP_AND  = 11'b10001010000;
  localparam logic [10:0] OP_ORR  = 11'b10101010000;
  localparam logic [10:0] OP_LDUR = 11'b11111000010;
  localparam logic [10:0] OP_STUR = 11'b11111000000;
  localparam logic [7:0]  OP_CBZ  = 8'b10110100;
  localparam logic [7:0]  OP_CBNZ = 8'b10110101;
  localparam logic [5:0]  OP_B    = 6'b000101;

  localparam logic [1:0] ALU_MEM = 2'b00;
  localparam logic [1:0] ALU_BR  = 2'b01;
  localparam logic [1:0] ALU_R   = 2'b10;

  typedef enum logic [2:0] {
    CLS_NOP, CLS_R, CLS_LDUR, CLS_STUR, CLS_CBZ, CLS_CBNZ, CLS_B
  } iclass_t;

  typedef struct packed {
    logic       branch;
    logic       branch_if_zero;
    logic       branch_if_not_zero;
    logic       mem_read;
    logic       mem_to_reg;
    logic       mem_write;
    logic       alu_src;
    logic       reg_write;
    logic [1:0] alu_op;
  } ctrl_t;

  // CB and B opcodes are shorter than 11 bits, so they match on a prefix only.
  function automatic iclass_t classify(input logic [10:0] op);
    iclass_t c;
    c = CLS_NOP;
    if (op == OP_ADD || op == OP_SUB || op == OP_AND || op == OP_ORR) c = CLS_R;
    else if (op == OP_LDUR)     c = CLS_LDUR;
    else if (op == OP_STUR)     c = CLS_STUR;
    else if (op[10:3] == OP_CBZ)  c = CLS_CBZ;
    else if (op[10:3] == OP_CBNZ) c = CLS_CBNZ;
    else if (op[10:5] == OP_B)    c = CLS_B;
    return c;
  endfunction

  function automatic ctrl_t ctrl_of(input iclass_t c);
    ctrl_t k;
    k = '0;
    case (c)
      CLS_R:    begin k.reg_write = 1'b1; k.alu_op = ALU_R; end
      CLS_LDUR: begin
        k.mem_read = 1'b1; k.mem_to_reg = 1'b1; k.alu_src = 1'b1;
        k.reg_write = 1'b1; k.alu_op = ALU_MEM;
      end
      CLS_STUR: begin k.mem_write = 1'b1; k.alu_src = 1'b1; k.alu_op = ALU_MEM; end
      CLS_CBZ:  begin k.branch_if_zero = 1'b1; k.alu_op = ALU_BR; end
      CLS_CBNZ: begin k.branch_if_not_zero = 1'b1; k.alu_op = ALU_BR; end
      CLS_B:    k.branch = 1'b1;
      default:  k = '0;
    endcase
    return k;
  endfunction

endpackage

// File: rtl/pipelined_decode_reg_file.sv
// Register file: two combinational read ports, one write port, hardwired zero register.
// Same-cycle write-through is enabled by defining DECODE_WB_BYPASS_EN.
module reg_file #(
  parameter int WORD     = 64,
  parameter int NUM_REGS = 32,
  parameter int ZERO_REG = NUM_REGS - 1
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [$clog2(NUM_REGS)-1:0] i_ra1,
  input  logic [$clog2(NUM_REGS)-1:0] i_ra2,
  output logic [WORD-1:0]             o_rd1,
  output logic [WORD-1:0]             o_rd2,
  input  logic                        i_we,
  input  logic [$clog2(NUM_REGS)-1:0] i_wa,
  input  logic [WORD-1:0]             i_wd
);
  localparam int RA = $clog2(NUM_REGS);
  localparam logic [RA-1:0] ZR = RA'(ZERO_REG);
`ifdef DECODE_WB_BYPASS_EN
  localparam logic BYPASS = 1'b1;
`else
  localparam logic BYPASS = 1'b0;
`endif

  logic [WORD-1:0] r_mem [NUM_REGS];
  logic            w_wr;
  logic            w_hit1;
  logic            w_hit2;

  assign w_wr   = i_we && (i_wa != ZR);
  assign w_hit1 = BYPASS && w_wr && (i_wa == i_ra1);
  assign w_hit2 = BYPASS && w_wr && (i_wa == i_ra2);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_REGS; i++) r_mem[i] <= '0;
    end else if (w_wr) begin
      r_mem[i_wa] <= i_wd;
    end
  end

  assign o_rd1 = (i_ra1 == ZR) ? '0 : (w_hit1 ? i_wd : r_mem[i_ra1]);
  assign o_rd2 = (i_ra2 == ZR) ? '0 : (w_hit2 ? i_wd : r_mem[i_ra2]);

endmodule

// File: rtl/pipelined_decode.sv
// LEGv8 decode stage with ID/EX output register, load-use stall and branch flush.
// Optional same-cycle write-back bypass: define DECODE_WB_BYPASS_EN.
module pipelined_decode
  import pipelined_decode_pkg::*;
#(
  parameter int WORD     = WORD_DEF,
  parameter int NUM_REGS = 32,
  parameter int ZERO_REG = NUM_REGS - 1
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        flush,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic [INSTR_LEN-1:0]        in_instruction,
  input  logic                        wb_en,
  input  logic [$clog2(NUM_REGS)-1:0] wb_reg,
  input  logic [WORD-1:0]             wb_data,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [10:0]                 out_opcode,
  output logic [$clog2(NUM_REGS)-1:0] out_rn,
  output logic [$clog2(NUM_REGS)-1:0] out_rr2,
  output logic [$clog2(NUM_REGS)-1:0] out_rd,
  output logic [WORD-1:0]             out_read_data1,
  output logic [WORD-1:0]             out_read_data2,
  output logic [WORD-1:0]             out_imm,
  output logic                        out_branch,
  output logic                        out_branch_if_zero,
  output logic                        out_branch_if_not_zero,
  output logic                        out_mem_read,
  output logic                        out_mem_to_reg,
  output logic                        out_mem_write,
  output logic                        out_alu_src,
  output logic                        out_reg_write,
  output logic [1:0]                  out_alu_op,
  output logic                        hazard_stall
);
  localparam int RA = $clog2(NUM_REGS);
  localparam logic [RA-1:0] ZR = RA'(ZERO_REG);

  logic [10:0]     w_opcode;
  iclass_t         w_cls;
  ctrl_t           w_ctrl;
  logic [RA-1:0]   w_rn, w_rr2, w_rd;
  logic [WORD-1:0] w_rd1, w_rd2, w_imm;
  logic            w_rn_used, w_rr2_used, w_accept;

  logic            r_valid;
  logic [10:0]     r_opcode;
  logic [RA-1:0]   r_rn, r_rr2, r_rd;
  logic [WORD-1:0] r_rd1, r_rd2, r_imm;
  ctrl_t           r_ctrl;

  assign w_opcode = in_instruction[31:21];
  assign w_cls    = classify(w_opcode);
  assign w_ctrl   = ctrl_of(w_cls);
  assign w_rn     = RA'(in_instruction[9:5]);
  assign w_rd     = RA'(in_instruction[4:0]);
  assign w_rr2    = (w_cls == CLS_STUR || w_cls == CLS_CBZ || w_cls == CLS_CBNZ)
                    ? RA'(in_instruction[4:0]) : RA'(in_instruction[20:16]);

  always_comb begin
    w_imm = '0;
    case (w_cls)
      CLS_LDUR, CLS_STUR: w_imm = {{(WORD-9){in_instruction[20]}}, in_instruction[20:12]};
      CLS_CBZ, CLS_CBNZ:  w_imm = {{(WORD-19){in_instruction[23]}}, in_instruction[23:5]};
      CLS_B:              w_imm = {{(WORD-26){in_instruction[25]}}, in_instruction[25:0]};
      default:            w_imm = '0;
    endcase
  end

  reg_file #(.WORD(WORD), .NUM_REGS(NUM_REGS), .ZERO_REG(ZERO_REG)) u_reg_file (
    .clk   (clk),
    .rst   (reset),
    .i_ra1 (w_rn),
    .i_ra2 (w_rr2),
    .o_rd1 (w_rd1),
    .o_rd2 (w_rd2),
    .i_we  (wb_en),
    .i_wa  (wb_reg),
    .i_wd  (wb_data)
  );

  // Load-use: the load sitting in ID/EX writes a register this instruction reads.
  assign w_rn_used    = (w_cls != CLS_B);
  assign w_rr2_used   = (w_cls == CLS_R) || (w_cls == CLS_STUR) ||
                        (w_cls == CLS_CBZ) || (w_cls == CLS_CBNZ);
  assign hazard_stall = in_valid && r_valid && r_ctrl.mem_read && (r_rd != ZR) &&
                        ((w_rn_used && r_rd == w_rn) || (w_rr2_used && r_rd == w_rr2));

  // Handshake: a transfer happens on a rising edge where valid and ready are both
  // high; valid never depends on ready. Flush always drains the input side.
  assign in_ready = flush || (!hazard_stall && (!r_valid || out_ready));
  assign w_accept = in_valid && in_ready;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_valid  <= 1'b0;
      r_opcode <= '0;
      r_rn     <= '0;
      r_rr2    <= '0;
      r_rd     <= '0;
      r_rd1    <= '0;
      r_rd2    <= '0;
      r_imm    <= '0;
      r_ctrl   <= '0;
    end else if (flush) begin
      r_valid <= 1'b0;
    end else if (w_accept) begin
      r_valid  <= 1'b1;
      r_opcode <= w_opcode;
      r_rn     <= w_rn;
      r_rr2    <= w_rr2;
      r_rd     <= w_rd;
      r_rd1    <= w_rd1;
      r_rd2    <= w_rd2;
      r_imm    <= w_imm;
      r_ctrl   <= w_ctrl;
    end else if (out_ready && (!in_valid || hazard_stall)) begin
      r_valid <= 1'b0;
    end
  end

  assign out_valid              = r_valid;
  assign out_opcode             = r_opcode;
  assign out_rn                 = r_rn;
  assign out_rr2                = r_rr2;
  assign out_rd                 = r_rd;
  assign out_read_data1         = r_rd1;
  assign out_read_data2         = r_rd2;
  assign out_imm                = r_imm;
  assign out_branch             = r_ctrl.branch;
  assign out_branch_if_zero     = r_ctrl.branch_if_zero;
  assign out_branch_if_not_zero = r_ctrl.branch_if_not_zero;
  assign out_mem_read           = r_ctrl.mem_read;
  assign out_mem_to_reg         = r_ctrl.mem_to_reg;
  assign out_mem_write          = r_ctrl.mem_write;
  assign out_alu_src            = r_ctrl.alu_src;
  assign out_reg_write          = r_ctrl.reg_write;
  assign out_alu_op             = r_ctrl.alu_op;

endmodule

// File: tb/tb_pipelined_decode.sv
// Directed bench for pipelined_decode: expected ID/EX contents are queued at accept
// and compared when execute consumes them.
module tb_pipelined_decode;
  localparam int W  = 64;
  localparam int EW = 11 + 15 + 3 * W + 10;
  // {branch, bz, bnz, mem_read, mem_to_reg, mem_write, alu_src, reg_write, alu_op}
  localparam logic [9:0] C_R    = 10'b0000000110;
  localparam logic [9:0] C_LDUR = 10'b0001101100;
  localparam logic [9:0] C_STUR = 10'b0000011000;
  localparam logic [9:0] C_CBZ  = 10'b0100000001;
  localparam logic [9:0] C_CBNZ = 10'b0010000001;
  localparam logic [9:0] C_B    = 10'b1000000000;
  localparam logic [9:0] C_NOP  = 10'b0000000000;

  logic        clk = 1'b0;
  logic        reset, flush, in_valid, in_ready, wb_en, out_valid, out_ready, hazard_stall;
  logic [31:0] in_instruction;
  logic [4:0]  wb_reg, out_rn, out_rr2, out_rd;
  logic [W-1:0] wb_data, out_read_data1, out_read_data2, out_imm;
  logic [10:0] out_opcode;
  logic        out_branch, out_branch_if_zero, out_branch_if_not_zero, out_mem_read;
  logic        out_mem_to_reg, out_mem_write, out_alu_src, out_reg_write;
  logic [1:0]  out_alu_op;

  int n_tests = 0;
  int n_fail  = 0;
  logic [EW-1:0] exp_q[$];
  logic [W-1:0]  model [32];
  logic [W-1:0]  byp_val;

  pipelined_decode dut (
    .clk(clk), .reset(reset), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .in_instruction(in_instruction), .wb_en(wb_en), .wb_reg(wb_reg), .wb_data(wb_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_opcode(out_opcode),
    .out_rn(out_rn), .out_rr2(out_rr2), .out_rd(out_rd),
    .out_read_data1(out_read_data1), .out_read_data2(out_read_data2), .out_imm(out_imm),
    .out_branch(out_branch), .out_branch_if_zero(out_branch_if_zero),
    .out_branch_if_not_zero(out_branch_if_not_zero), .out_mem_read(out_mem_read),
    .out_mem_to_reg(out_mem_to_reg), .out_mem_write(out_mem_write),
    .out_alu_src(out_alu_src), .out_reg_write(out_reg_write), .out_alu_op(out_alu_op),
    .hazard_stall(hazard_stall)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [EW-1:0] obs, input logic [EW-1:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [EW-1:0] pack(input logic [31:0] instr, input logic [4:0] rr2,
                                         input logic [W-1:0] rd1, input logic [W-1:0] rd2,
                                         input logic [W-1:0] imm, input logic [9:0] ctrl);
    return {instr[31:21], instr[9:5], rr2, instr[4:0], rd1, rd2, imm, ctrl};
  endfunction

  // ---------------- scoreboard ----------------
  always @(negedge clk) begin
    if (!reset && out_valid && flush) begin
      if (exp_q.size() > 0) void'(exp_q.pop_front());
    end else if (!reset && out_valid && out_ready) begin
      if (exp_q.size() == 0) check("unexpected_output", 1, 0);
      else check("id_ex_fields",
                 {out_opcode, out_rn, out_rr2, out_rd, out_read_data1, out_read_data2, out_imm,
                  out_branch, out_branch_if_zero, out_branch_if_not_zero, out_mem_read,
                  out_mem_to_reg, out_mem_write, out_alu_src, out_reg_write, out_alu_op},
                 exp_q.pop_front());
    end
  end

  // ---------------- drivers ----------------
  task automatic idle();
    @(posedge clk); #1;
  endtask

  task automatic wb_write(input logic [4:0] r, input logic [W-1:0] d);
    wb_en = 1'b1; wb_reg = r; wb_data = d;
    idle();
    wb_en = 1'b0;
    if (r != 5'd31) model[r] = d;
  endtask

  task automatic send(input logic [31:0] instr, input logic [4:0] rr2, input logic [W-1:0] rd1,
                      input logic [W-1:0] rd2, input logic [W-1:0] imm, input logic [9:0] ctrl);
    int waited = 0;
    in_valid = 1'b1; in_instruction = instr;
    forever begin
      @(negedge clk);
      if (in_ready) break;
      waited++;
      if (waited > 20) begin
        check("accept_timeout", 0, 1);
        in_valid = 1'b0;
        return;
      end
    end
    exp_q.push_back(pack(instr, rr2, rd1, rd2, imm, ctrl));
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [31:0] ins;
    logic [4:0]  rm;
    reset = 1'b1; flush = 1'b0; in_valid = 1'b0; in_instruction = '0;
    wb_en = 1'b0; wb_reg = '0; wb_data = '0; out_ready = 1'b1;
    for (int i = 0; i < 32; i++) model[i] = '0;
    #1;
    check("reset_out_valid", out_valid, 0);
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    check("reset_in_ready", in_ready, 1);
    check("reset_hazard", hazard_stall, 0);
    check("reset_fields", {out_opcode, out_rd, out_read_data1, out_read_data2, out_imm, out_alu_op},
          0);

    // every register reads zero after reset
    for (int i = 0; i <= 30; i += 2) begin
      rm  = (i == 30) ? 5'd30 : 5'(i + 1);
      ins = {11'h550, rm, 6'd0, 5'(i), 5'($urandom_range(0, 30))};
      send(ins, rm, model[i], model[rm], '0, C_R);
    end

    wb_write(5'd1, 64'h5);
    wb_write(5'd2, 64'h7);
    send({11'h458, 5'd2, 6'd0, 5'd1, 5'd3}, 5'd2, 64'h5, 64'h7, '0, C_R);

    // load-use: LDUR X4,[X1,#8] then ADD X5,X4,X2
    send({11'h7C2, 9'd8, 2'b00, 5'd1, 5'd4}, 5'd0, 64'h5, 64'h0, 64'd8, C_LDUR);
    in_valid = 1'b1; in_instruction = {11'h458, 5'd2, 6'd0, 5'd4, 5'd5};
    #1;
    check("stall_hazard", hazard_stall, 1);
    check("stall_in_ready", in_ready, 0);
    idle();
    check("bubble_out_valid", out_valid, 0);
    check("post_stall_in_ready", in_ready, 1);
    send({11'h458, 5'd2, 6'd0, 5'd4, 5'd5}, 5'd2, 64'h0, 64'h7, '0, C_R);

    send({11'h7C0, 9'h1FF, 2'b00, 5'd1, 5'd2}, 5'd2, 64'h5, 64'h7, '1, C_STUR);
    wb_write(5'd31, 64'hFF);
    send({8'hB4, 19'h7FFFF, 5'd31}, 5'd31, '0, '0, '1, C_CBZ);
    send({8'hB5, 19'h4, 5'd1}, 5'd1, model[4], 64'h5, 64'h4, C_CBNZ);
    send({6'b000101, 26'h2000023}, 5'd0, 64'h5, 64'h0, 64'hFFFF_FFFF_FE00_0023, C_B);
    send(32'hFFFF_FFFF, 5'd31, '0, '0, '0, C_NOP);

    // back-pressure then flush
    idle();
    out_ready = 1'b0;
    send({11'h458, 5'd2, 6'd0, 5'd1, 5'd3}, 5'd2, 64'h5, 64'h7, '0, C_R);
    in_valid = 1'b1; in_instruction = {11'h658, 5'd2, 6'd0, 5'd1, 5'd8};
    for (int k = 0; k < 3; k++) begin
      #1;
      check("bp_in_ready", in_ready, 0);
      check("bp_hold", {out_valid, out_opcode, out_read_data1, out_read_data2},
            {1'b1, 11'h458, 64'h5, 64'h7});
      idle();
    end
    flush = 1'b1;
    #1 check("flush_in_ready", in_ready, 1);
    idle();
    flush = 1'b0; in_valid = 1'b0;
    check("flush_out_valid", out_valid, 0);
    out_ready = 1'b1;

    // same-cycle write-back vs read
`ifdef DECODE_WB_BYPASS_EN
    byp_val = 64'h9;
`else
    byp_val = 64'h0;
`endif
    wb_en = 1'b1; wb_reg = 5'd6; wb_data = 64'h9;
    send({11'h458, 5'd6, 6'd0, 5'd6, 5'd7}, 5'd6, byp_val, byp_val, '0, C_R);
    wb_en = 1'b0; model[6] = 64'h9;
    send({11'h458, 5'd6, 6'd0, 5'd6, 5'd7}, 5'd6, 64'h9, 64'h9, '0, C_R);

    for (int t = 0; t < 10 && exp_q.size() != 0; t++) idle();
    check("queue_drained", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
